div_hilo_ctrl: RTL and testbench
================================

Name: div_hilo_ctrl

Overview:
- Sequencing stage wrapped around the combinational signed divider in the ALU datapath.
- Accepts a DIV request from the datapath and registers the operands. It presents magnitudes to the divider and waits a fixed number of cycles for the deep combinational path to settle.
- It then applies sign correction and special-case handling, and writes the quotient to LO and the remainder to HI.
- Consumers are the HI/LO register moves (mfhi/mflo); results hold until the next accepted DIV.

Parameters:
SETTLE_CYCLES, 2, cycles the registered operands are held before results are captured (multicycle path budget); legal range 1..15.

Ports:
clock  input  1  system clock, rising-edge.
clear_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only while busy=0.
dividend  input  32  signed dividend, valid in the start cycle.
divisor  input  32  signed divisor, valid in the start cycle.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse; hi/lo/div_by_zero valid from this cycle.
hi  output  32  remainder register.
lo  output  32  quotient register.
div_by_zero  output  1  sticky per-operation flag, updated at capture.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - Settle counter=0; operand registers=0.
  - Reset mid-operation aborts the operation with no capture.
- States: IDLE, SETTLE, CAPTURE.
- IDLE:
  - If start=1, register the operands.
  - Also register the special-case decode: sgn_q = dividend[31]^divisor[31]; sgn_r = dividend[31]; zero = (divisor==0); ovf = (dividend==32'h8000_0000 && divisor==32'hFFFF_FFFF).
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
  - done is deasserted in any cycle other than the CAPTURE cycle.
- SETTLE:
  - busy=1.
  - Divider inputs are |dividend_r| and |divisor_r| (two's-complement negate when negative; 0x8000_0000 passes unchanged).
  - Decrement the counter; at 0 go to CAPTURE.
- CAPTURE:
  - Load hi/lo per the rules below, pulse done=1, drop busy, return to IDLE.
  - start in the CAPTURE cycle is ignored; a new start is accepted in the following IDLE cycle.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+SETTLE_CYCLES+1. Latency is the same for all operand values, special cases included.
- Result rules, in priority order:
  - zero: lo=32'hFFFF_FFFF, hi=dividend_r, div_by_zero=1.
  - ovf: lo=32'h8000_0000, hi=0, div_by_zero=0.
  - otherwise: lo = sgn_q ? -q : q; hi = sgn_r ? -r : r; div_by_zero=0. Here q and r are the unsigned divider outputs.
  - Remainder sign follows the dividend (truncating division).
- start while busy=1 is ignored; no queueing and no error flag.
- Operand inputs are don't-care except in the accepting cycle.
- hi/lo change only in the CAPTURE cycle or on reset.

Decomposition:
- Shared ALU package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_CAPTURE=2'd2.
  - DIV0_QUOTIENT=32'hFFFF_FFFF.
  - INT_MIN=32'h8000_0000.
- One sub-module instance: the existing combinational divider, fed magnitudes only.
- The sign-fixup and negate logic stays inline.

Test Plan:
- dividend=7, divisor=2, start one cycle -> done after SETTLE_CYCLES+2 cycles; lo=3, hi=1, div_by_zero=0; busy high for exactly SETTLE_CYCLES+1 cycles.
- dividend=-7 (0xFFFF_FFF9), divisor=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. dividend=7, divisor=-2 -> lo=0xFFFF_FFFD, hi=1. dividend=-7, divisor=-2 -> lo=3, hi=0xFFFF_FFFF.
- dividend=0x1234, divisor=0 -> lo=0xFFFF_FFFF, hi=0x1234, div_by_zero=1. A following 9/3 -> lo=3, hi=0, div_by_zero=0.
- dividend=0x8000_0000, divisor=0xFFFF_FFFF -> lo=0x8000_0000, hi=0. dividend=0x8000_0000, divisor=2 -> lo=0xC000_0000, hi=0.
- Accept 100/7, then pulse start with 5/5 while busy -> single done; lo=14, hi=2. start=1 held continuously -> back-to-back operations spaced SETTLE_CYCLES+2 cycles apart.
- Accept 100/7, assert clear_n=0 in SETTLE -> busy/done/hi/lo/div_by_zero all 0 immediately. After release, no done pulse occurs until a new start is accepted.

Source files
------------

// File: rtl/div_hilo_ctrl_pkg.sv
// Shared ALU definitions for the HI/LO divide sequencer: state encoding,
// special-case result constants and the registered decode of a request.
package div_hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } div_state_t;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Special cases decoded once at acceptance so the capture stage sees stable flags.
  typedef struct packed {
    logic sgn_q;
    logic sgn_r;
    logic zero;
    logic ovf;
  } div_flags_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_hilo_ctrl_divu.sv
// Combinational 32-bit unsigned restoring divider. Deep path; the sequencer
// holds its inputs steady for a multicycle budget before sampling.
module div_hilo_ctrl_divu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [32:0] rem_v;
  logic [31:0] quo_v;

  // A zero divisor yields all-ones quotient and r=a; the caller overrides it.
  always_comb begin
    rem_v = '0;
    quo_v = '0;
    for (int i = 31; i >= 0; i--) begin
      rem_v = {rem_v[31:0], a[i]};
      if (rem_v >= {1'b0, b}) begin
        rem_v    = rem_v - {1'b0, b};
        quo_v[i] = 1'b1;
      end
    end
  end

  assign q = quo_v;
  assign r = rem_v[31:0];

endmodule

// File: rtl/div_hilo_ctrl.sv
// DIV sequencer: registers a signed request, waits SETTLE_CYCLES for the
// combinational divider, then sign-corrects into LO (quotient) / HI (remainder).
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a request taken only when busy=0 (IDLE); the cycle it
  // is taken is the acceptance cycle and operands must be valid then. busy
  // rises the next cycle and falls as done pulses; requests while busy are dropped.

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  div_state_t  state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] dividend_r, divisor_r;
  div_flags_t  flags_r;
  logic        accept;

  logic [31:0] mag_a, mag_b, div_q, div_r;
  logic [31:0] cap_hi, cap_lo;
  logic        cap_dbz;

  assign accept    = (state == ST_IDLE) && start;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (cnt == 4'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mag_a = abs32(dividend_r);
    mag_b = abs32(divisor_r);
    cap_dbz = 1'b0;
    if (flags_r.zero) begin
      cap_lo  = DIV0_QUOTIENT;
      cap_hi  = dividend_r;
      cap_dbz = 1'b1;
    end else if (flags_r.ovf) begin
      cap_lo = INT_MIN;
      cap_hi = 32'd0;
    end else begin
      cap_lo = flags_r.sgn_q ? neg32(div_q) : div_q;
      cap_hi = flags_r.sgn_r ? neg32(div_r) : div_r;
    end
  end

  div_hilo_ctrl_divu u_divu (
    .a (mag_a),
    .b (mag_b),
    .q (div_q),
    .r (div_r)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt        <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      flags_r    <= '0;
    end else if (accept) begin
      cnt           <= CNT_LOAD;
      dividend_r    <= dividend;
      divisor_r     <= divisor;
      flags_r.sgn_q <= dividend[31] ^ divisor[31];
      flags_r.sgn_r <= dividend[31];
      flags_r.zero  <= (divisor == 32'd0);
      flags_r.ovf   <= (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
    end else if (state == ST_SETTLE && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // busy tracks "not IDLE"; results and done register on the edge leaving CAPTURE.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_CAPTURE);
      if (state == ST_CAPTURE) begin
        hi          <= cap_hi;
        lo          <= cap_lo;
        div_by_zero <= cap_dbz;
      end
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl: directed and random signed divides,
// special cases, busy-drop, back-to-back and mid-operation reset.
module tb_div_hilo_ctrl;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  logic [64:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  div_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: SV signed division truncates; % takes the dividend's sign.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
    q = 32'($signed(a) / $signed(b));
    r = 32'($signed(a) % $signed(b));
    return {1'b0, r, q};
  endfunction

  // Scoreboard side: every done pops one expectation.
  always @(negedge clock) begin
    if (clear_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check_val("unexpected_done", 65'd1, 65'd0);
      else check_val("result", {div_by_zero, hi, lo}, exp_q.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (busy) check_val("idle_timeout", 65'd1, 65'd0);
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1; lat++;
      if (busy) nbusy++;
    end
    if (!done) check_val("done_timeout", 65'd1, 65'd0);
  endtask

  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic drive_div(input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
    int lat, nb;
    drive_div(a, b, exp);
    wait_done(lat, nb);
    @(posedge clock); #1;
  endtask

  initial begin
    int lat, nb, d0, prev;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clock);
    #1;
    check_val("reset_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
    clear_n = 1'b1;
    @(posedge clock); #1;

    drive_div(32'd7, 32'd2, {1'b0, 32'd1, 32'd3});
    wait_done(lat, nb);
    check_val("latency", 65'(lat), 65'(S + 2));
    check_val("busy_cycles", 65'(nb), 65'(S + 1));
    @(posedge clock); #1;

    run_div(32'hFFFF_FFF9, 32'd2,          {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(32'd7,         32'hFFFF_FFFE,  {1'b0, 32'd1,         32'hFFFF_FFFD});
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE,  {1'b0, 32'hFFFF_FFFF, 32'd3});
    run_div(32'h1234,      32'd0,          {1'b1, 32'h1234,      32'hFFFF_FFFF});
    run_div(32'd9,         32'd3,          {1'b0, 32'd0,         32'd3});
    run_div(32'h8000_0000, 32'hFFFF_FFFF,  {1'b0, 32'd0,         32'h8000_0000});
    run_div(32'h8000_0000, 32'd2,          {1'b0, 32'd0,         32'hC000_0000});

    // start pulsed while busy must be dropped
    d0 = done_cnt;
    drive_div(32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    dividend = 32'd5; divisor = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat, nb);
    repeat (3 * S + 6) @(posedge clock);
    #1;
    check_val("busy_start_dropped", 65'(done_cnt - d0), 65'd1);
    check_val("hold_after_done", {div_by_zero, hi, lo}, {1'b0, 32'd2, 32'd14});

    // start held high: back-to-back operations
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    repeat (3) exp_q.push_back({1'b0, 32'd0, 32'd3});
    @(posedge clock); #1;
    wait_done(lat, nb);
    check_val("b2b_first", 65'(lat), 65'(S + 2));
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      wait_done(lat, nb);
      check_val("b2b_spacing", 65'(lat), 65'(S + 2));
    end
    start = 1'b0;
    @(posedge clock); #1;

    // random signed operands against the model
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = -32'($urandom_range(1, 20));
        2: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      if (k == 5) rb = 32'd0;
      run_div(ra, rb, model(ra, rb));
    end

    // reset during SETTLE aborts with no capture
    d0 = done_cnt;
    drive_div(32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    void'(exp_q.pop_back());
    clear_n = 1'b0;
    #1;
    check_val("abort_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
    @(posedge clock); #1;
    clear_n = 1'b1;
    repeat (S + 6) @(posedge clock);
    #1;
    check_val("abort_no_done", 65'(done_cnt - d0), 65'd0);
    check_val("abort_idle", {63'd0, dbg_state}, 65'd0);

    prev = done_cnt;
    run_div(32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    check_val("post_abort_done", 65'(done_cnt - prev), 65'd1);

    check_val("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
